// File: rtl/seg7_number_display_if.sv
// Value/mode request and seven-segment image bundle for seg7_number_display.
// The master drives the number to show; the slave returns the segment image and status.
interface seg7_number_display_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) ();
  logic [WIDTH-1:0]    value;
  logic                hex_mode;
  logic [7*DIGITS-1:0] segments;
  logic                busy;
  logic                overflow;

  modport master (
    output value,
    output hex_mode,
    input  segments,
    input  busy,
    input  overflow
  );

  modport slave (
    input  value,
    input  hex_mode,
    output segments,
    output busy,
    output overflow
  );
endinterface

// File: rtl/seg7_number_display.sv
// Binary to seven-segment display driver, decimal via serial double-dabble or direct hex.
// Define SEG7_NUMBER_DISPLAY_LZB_EN to blank leading zero digits.
module seg7_number_display #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic                  clock,
  input logic                  reset_n,
  seg7_number_display_if.slave bus
);
  // Five BCD digits cover the largest legal input (65535), so overflow is visible in the upper nibbles.
  localparam int unsigned BcdW = 20;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    cap_value_q, cap_value_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                cap_hex_q, cap_hex_d;
  logic                done_q, done_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj, src;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_img;
  logic                ovf_q, ovf_d, ovf_img;
  logic                start, last_bit;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign start    = !done_q || (bus.value != cap_value_q) || (bus.hex_mode != cap_hex_q);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = bus.hex_mode ? StUpdate : StConvert;
      StConvert: if (last_bit) state_d = StUpdate;
      StUpdate:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdW / 4); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next display image; decimal reads the finished BCD, hex reads the captured value directly.
  always_comb begin
`ifdef SEG7_NUMBER_DISPLAY_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    src     = cap_hex_q ? BcdW'(cap_value_q) : bcd_q;
    ovf_img = |(src >> (4 * DIGITS));
    seg_img = '1;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
`ifdef SEG7_NUMBER_DISPLAY_LZB_EN
      if (lead && (src[4*d +: 4] == 4'd0) && (d != 0)) begin
        seg_img[7*d +: 7] = 7'h7F;
      end else begin
        lead              = 1'b0;
        seg_img[7*d +: 7] = glyph(src[4*d +: 4]);
      end
`else
      seg_img[7*d +: 7] = glyph(src[4*d +: 4]);
`endif
    end
  end

  always_comb begin
    cap_value_d = cap_value_q;
    cap_hex_d   = cap_hex_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    seg_d       = seg_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cap_value_d = bus.value;
          cap_hex_d   = bus.hex_mode;
          shift_d     = bus.value;
          bcd_d       = '0;
          cnt_d       = '0;
        end
      end
      StConvert: begin
        bcd_d   = BcdW'({bcd_adj, shift_q[WIDTH-1]});
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CntW'(1);
      end
      StUpdate: begin
        seg_d  = seg_img;
        ovf_d  = ovf_img;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_value_q <= '0;
      cap_hex_q   <= 1'b0;
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      seg_q       <= '1;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cap_value_q <= cap_value_d;
      cap_hex_q   <= cap_hex_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      seg_q       <= seg_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.segments = seg_q;
  assign bus.overflow = ovf_q;
endmodule
